// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: memory opcode encodings, FSM states and lane constants shared by the load/store unit.
package mem_access_unit_pkg;
  localparam int LANES = 4;
  localparam int DW = LANES * 8;
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mau_lane_align: byte-lane store shift/mask and load shift/extend for one 4-byte word.
module mau_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]    op,
  input  logic [1:0]    off_raw,
  input  logic [DW-1:0] st_data,
  input  logic [DW-1:0] ld_raw,
  output logic [DW-1:0] st_wdata,
  output logic [3:0]    st_wmask,
  output logic [DW-1:0] ld_data
);
  logic is_b, is_h, uns;
  logic [1:0] off;
  logic [DW-1:0] ld_sh;
  always_comb begin
    is_b = (op == MEM_B) || (op == MEM_BU);
    is_h = (op == MEM_H) || (op == MEM_HU);
    uns = (op == MEM_BU) || (op == MEM_HU);
    // Misaligned halves/words drop the offending low bits; reserved ops fall into the word path
    off = is_b ? off_raw : is_h ? {off_raw[1], 1'b0} : 2'b00;
    st_wdata = is_b ? {24'b0, st_data[7:0]} << {off, 3'b000} :
               is_h ? {16'b0, st_data[15:0]} << {off, 3'b000} : st_data;
    st_wmask = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
    ld_sh = ld_raw >> {off, 3'b000};
    ld_data = is_b ? {{24{~uns & ld_sh[7]}}, ld_sh[7:0]} :
              is_h ? {{16{~uns & ld_sh[15]}}, ld_sh[15:0]} : ld_sh;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store stage over a valid/ready memory bus.
// Define MAU_MISALIGN_CHECK_EN to flag misaligned H/W accesses via out_err instead of issuing them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_we,
  input  logic [2:0]       in_mem_op,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_wen,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic             mem_rsp_valid,
  output logic             mem_rsp_ready,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rdata,
  output logic             out_err
);
  state_e state_q, state_d;
  logic we_q, we_d, err_q, err_d, mis;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [WIDTH-1:0] st_wdata, ld_data;
  logic [3:0] st_wmask;

  mau_lane_align u_align (
    .op      (op_q),
    .off_raw (addr_q[1:0]),
    .st_data (wdata_q),
    .ld_raw  (mem_rsp_data),
    .st_wdata(st_wdata),
    .st_wmask(st_wmask),
    .ld_data (ld_data)
  );

`ifdef MAU_MISALIGN_CHECK_EN
  assign mis = ((in_mem_op == MEM_H || in_mem_op == MEM_HU) && in_addr[0]) ||
               (in_mem_op != MEM_B && in_mem_op != MEM_BU && in_mem_op != MEM_H &&
                in_mem_op != MEM_HU && in_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d = we_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        we_d = in_we;
        op_d = in_mem_op;
        addr_d = in_addr;
        wdata_d = in_wdata;
        rdata_d = '0;
        err_d = mis;
        state_d = mis ? S_DONE : S_REQ;
      end
      S_REQ: state_d = mem_req_ready ? S_WAIT : S_REQ;
      S_WAIT: if (mem_rsp_valid) begin
        rdata_d = we_q ? '0 : ld_data;
        state_d = S_DONE;
      end
      default: state_d = out_ready ? S_IDLE : S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q <= 1'b0;
      op_q <= 3'b000;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end

  // Bus fields are gated to REQ so an idle or reset unit presents all zeros
  assign in_ready = state_q == S_IDLE;
  assign mem_req_valid = state_q == S_REQ;
  assign mem_addr = mem_req_valid ? {addr_q[WIDTH-1:2], 2'b00} : '0;
  assign mem_wen = mem_req_valid & we_q;
  assign mem_wdata = (mem_req_valid & we_q) ? st_wdata : '0;
  assign mem_wmask = (mem_req_valid & we_q) ? st_wmask : 4'b0000;
  assign mem_rsp_ready = state_q == S_WAIT;
  assign out_valid = state_q == S_DONE;
  assign out_rdata = rdata_q;
  assign out_err = err_q;
endmodule
